aidc_lite_comp_cfg_mq: RTL

//  APB-programmed multi-channel descriptor front end for the AIDC-Lite compressor. Software stages
//  SRC/DST/LEN per channel and pushes them into a per-channel descriptor queue. Each channel hands

---
 rtl/aidc_lite_cfg_pkg.sv | 29 ++
 rtl/aidc_lite_comp_cfg_mq_if.sv | 21 ++
 rtl/aidc_lite_desc_fifo.sv | 73 +++++++
 rtl/aidc_lite_comp_cfg_mq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_cfg_pkg.sv
// Shared types and register map for the AIDC-Lite multi-channel descriptor front end.
package aidc_lite_cfg_pkg;

   // One queued descriptor; len keeps only the 128-byte-unit bits of the byte length.
   typedef struct packed {
      logic [31:0] src;
      logic [31:0] dst;
      logic [31:7] len;
   } desc_t;

   // Per-channel register offsets (word index, paddr[7:2]).
   localparam logic [5:0] OFF_SRC      = 6'd0;
   localparam logic [5:0] OFF_DST      = 6'd1;
   localparam logic [5:0] OFF_LEN      = 6'd2;
   localparam logic [5:0] OFF_CMD      = 6'd3;
   localparam logic [5:0] OFF_STATUS   = 6'd4;
   localparam logic [5:0] OFF_DONE_CNT = 6'd5;

   // Global register offsets (paddr[11] = 1).
   localparam logic [5:0] GOFF_IRQ_STAT = 6'd0;
   localparam logic [5:0] GOFF_IRQ_MASK = 6'd1;

   // STATUS bit positions; occupancy lives in [7:0].
   localparam int ST_FULL  = 8;
   localparam int ST_EMPTY = 9;
   localparam int ST_BUSY  = 10;
   localparam int ST_OVF   = 11;

endpackage

// File: rtl/aidc_lite_comp_cfg_mq_if.sv
// APB bus bundle used between the host bridge and the descriptor front end.
interface APB_INTF;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/aidc_lite_desc_fifo.sv
// Per-channel descriptor queue: registered pointers, head entry drives the read port directly.
module aidc_lite_desc_fifo
   import aidc_lite_cfg_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  desc_t                  wdata_i,
   output desc_t                  rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] occ_o
);

   localparam int AW = $clog2(DEPTH);

   desc_t         mem_q [DEPTH];
   desc_t         mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d;
   logic          push_ok, pop_ok;

   assign full_o  = (occ_q == (AW+1)'(DEPTH));
   assign empty_o = (occ_q == '0);
   assign occ_o   = occ_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A push into a full queue or a pop from an empty one is ignored here as a safety net.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Next-state for storage, pointers (natural power-of-2 wrap) and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   // State registers; reset clears contents so the head outputs read zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: rtl/aidc_lite_comp_cfg_mq.sv
// AIDC-Lite APB descriptor front end: per-channel shadow registers, descriptor queues,
// busy/completion tracking. Optional interrupt logic is built when AIDC_LITE_CFG_IRQ_EN
// is defined; otherwise the IRQ registers read 0 and irq_o is tied low.
module aidc_lite_comp_cfg_mq
   import aidc_lite_cfg_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int QDEPTH = 4,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   APB_INTF.slave                  apb_if,
   output logic [NUM_CH-1:0][31:0] src_addr_o,
   output logic [NUM_CH-1:0][31:0] dst_addr_o,
   output logic [NUM_CH-1:0][24:0] len_o,
   output logic [NUM_CH-1:0]       desc_vld_o,
   input  logic [NUM_CH-1:0]       desc_rdy_i,
   input  logic [NUM_CH-1:0]       done_i,
   output logic                    irq_o
);

   localparam int OCC_W = $clog2(QDEPTH) + 1;

   logic        wr_en, rd_setup, glb;
   logic [2:0]  ch_sel;
   logic [5:0]  off;
   logic [31:0] rd_data;
   logic [31:0] prdata_q, prdata_d;
   logic        unused_paddr;

   logic [NUM_CH-1:0][31:0] src_w, dst_w, status_w, cnt_w;
   logic [NUM_CH-1:0][24:0] len_w;
   logic [NUM_CH-1:0]       drop_w;

   assign wr_en        = apb_if.psel & apb_if.penable & apb_if.pwrite;
   assign rd_setup     = apb_if.psel & ~apb_if.penable & ~apb_if.pwrite;
   assign glb          = apb_if.paddr[11];
   assign ch_sel       = apb_if.paddr[10:8];
   assign off          = apb_if.paddr[7:2];
   assign unused_paddr = ^apb_if.paddr[1:0];

   assign apb_if.pready  = 1'b1;
   assign apb_if.pslverr = |drop_w;
   assign apb_if.prdata  = prdata_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [31:0]      src_q, src_d;
      logic [31:0]      dst_q, dst_d;
      logic [24:0]      len_q, len_d;
      logic             busy_q, busy_d;
      logic             ovf_q, ovf_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             wr_ch, push_req, push, drop, pop, cnt_clr;
      logic             full, empty;
      logic [OCC_W-1:0] occ;
      desc_t            wdesc, head;

      assign wr_ch    = wr_en & ~glb & (ch_sel == 3'(c));
      assign push_req = wr_ch & (off == OFF_CMD) & apb_if.pwdata[0];
      // Full is the registered flag, so a same-cycle pop cannot make room for this push.
      assign push     = push_req & ~full;
      assign drop     = push_req & full;
      assign pop      = ~empty & desc_rdy_i[c];
      assign cnt_clr  = wr_ch & (off == OFF_DONE_CNT);
      assign wdesc    = '{src: src_q, dst: dst_q, len: len_q};

      aidc_lite_desc_fifo #(
         .DEPTH (QDEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push_i  (push),
         .pop_i   (pop),
         .wdata_i (wdesc),
         .rdata_o (head),
         .full_o  (full),
         .empty_o (empty),
         .occ_o   (occ)
      );

      // Shadow register writes, busy tracking, overflow sticky and saturating done counter.
      always_comb begin
         src_d  = src_q;
         dst_d  = dst_q;
         len_d  = len_q;
         busy_d = busy_q;
         ovf_d  = ovf_q;
         cnt_d  = cnt_q;
         if (wr_ch) begin
            case (off)
               OFF_SRC: src_d = apb_if.pwdata;
               OFF_DST: dst_d = apb_if.pwdata;
               OFF_LEN: len_d = apb_if.pwdata[31:7];
               default: ;
            endcase
         end
         // A pop wins over a same-cycle completion: the new job is now running.
         if (pop) begin
            busy_d = 1'b1;
         end else if (done_i[c]) begin
            busy_d = 1'b0;
         end
         if (drop) begin
            ovf_d = 1'b1;
         end
         if (cnt_clr) begin
            ovf_d = 1'b0;
            cnt_d = done_i[c] ? CNT_W'(1) : '0;
         end else if (done_i[c] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Per-channel registers.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
         end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            len_q  <= len_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
         end
      end

      // STATUS word assembly.
      always_comb begin
         status_w[c]           = '0;
         status_w[c][7:0]      = 8'(occ);
         status_w[c][ST_FULL]  = full;
         status_w[c][ST_EMPTY] = empty;
         status_w[c][ST_BUSY]  = busy_q;
         status_w[c][ST_OVF]   = ovf_q;
      end

      assign src_w[c]      = src_q;
      assign dst_w[c]      = dst_q;
      assign len_w[c]      = len_q;
      assign cnt_w[c]      = 32'(cnt_q);
      assign drop_w[c]     = drop;
      assign src_addr_o[c] = head.src;
      assign dst_addr_o[c] = head.dst;
      assign len_o[c]      = head.len;
      assign desc_vld_o[c] = ~empty;
   end

`ifdef AIDC_LITE_CFG_IRQ_EN
   logic [NUM_CH-1:0] irq_stat_q, irq_stat_d;
   logic [NUM_CH-1:0] irq_mask_q, irq_mask_d;
   logic              irq_q, irq_d;

   // IRQ status W1C with completion set taking priority; irq follows status one cycle later.
   always_comb begin
      irq_stat_d = irq_stat_q;
      irq_mask_d = irq_mask_q;
      if (wr_en && glb && (off == GOFF_IRQ_STAT)) begin
         irq_stat_d = irq_stat_q & ~apb_if.pwdata[NUM_CH-1:0];
      end
      if (wr_en && glb && (off == GOFF_IRQ_MASK)) begin
         irq_mask_d = apb_if.pwdata[NUM_CH-1:0];
      end
      irq_stat_d = irq_stat_d | done_i;
      irq_d      = |(irq_stat_q & irq_mask_q);
   end

   // Interrupt registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_stat_q <= '0;
         irq_mask_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         irq_stat_q <= irq_stat_d;
         irq_mask_q <= irq_mask_d;
         irq_q      <= irq_d;
      end
   end

   assign irq_o = irq_q;
`else
   assign irq_o = 1'b0;
`endif

   // Read mux; anything not decoded returns zero.
   always_comb begin
      rd_data = '0;
      if (glb) begin
`ifdef AIDC_LITE_CFG_IRQ_EN
         case (off)
            GOFF_IRQ_STAT: rd_data = 32'(irq_stat_q);
            GOFF_IRQ_MASK: rd_data = 32'(irq_mask_q);
            default:       rd_data = '0;
         endcase
`endif
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 3'(c)) begin
               case (off)
                  OFF_SRC:      rd_data = src_w[c];
                  OFF_DST:      rd_data = dst_w[c];
                  OFF_LEN:      rd_data = {len_w[c], 7'b0};
                  OFF_STATUS:   rd_data = status_w[c];
                  OFF_DONE_CNT: rd_data = cnt_w[c];
                  default:      rd_data = '0;
               endcase
            end
         end
      end
   end

   // Read data is captured in the setup phase and held through the access phase.
   always_comb begin
      prdata_d = rd_setup ? rd_data : prdata_q;
   end

   // Read data register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prdata_q <= '0;
      end else begin
         prdata_q <= prdata_d;
      end
   end

endmodule
